// File: rtl/speck_pkg.sv
// Shared constants and controller state type for the SPECK128/128 round-key path.
package speck_pkg;
  localparam int SPECK_WORD_W   = 64;
  localparam int SPECK_KEY_W    = 128;
  localparam int SPECK_ROUNDS   = 32;
  localparam int KS_TIMEOUT_CYC = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KICK = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } rk_ctrl_state_t;
endpackage

// File: rtl/speck_rk_ram.sv
// Round-key buffer: one synchronous write port, one registered read port
// (a read of the address being written returns the previous contents).
module speck_rk_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_data_q <= '0;
    else         rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/speck_round_key_ctrl.sv
// Sequencer driving an external SPECK128/128 key_schedule block once per round and
// buffering every round key. Optional watchdog on WAIT: define SPECK_KS_TIMEOUT_EN.
// Handshake: a key transfers on the rising edge where key_valid && key_ready are both
// high; key_ready is only high in IDLE and the source must hold key/key_valid until then.
module speck_round_key_ctrl
  import speck_pkg::*;
#(
  parameter int ROUNDS = SPECK_ROUNDS,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [SPECK_KEY_W-1:0]  key,
  output logic                    keys_valid,
  output logic                    done,
  input  logic [ADDR_W-1:0]       rk_rd_addr,
  output logic [SPECK_WORD_W-1:0] rk_rd_data,
  output logic                    ks_start,
  output logic [SPECK_KEY_W-1:0]  ks_key,
  output logic [SPECK_WORD_W-1:0] ks_round_ctr,
  input  logic                    ks_finished,
  input  logic [SPECK_KEY_W-1:0]  ks_out_key,
  input  logic [3:0]              ks_state,
  output rk_ctrl_state_t          dbg_state
`ifdef SPECK_KS_TIMEOUT_EN
  ,
  output logic                    ks_timeout
`endif
);
  localparam logic [ADDR_W-1:0] LAST_ROUND = ADDR_W'(ROUNDS - 2);

  rk_ctrl_state_t          state_q, state_d;
  logic [SPECK_KEY_W-1:0]  kl_q, kl_d;
  logic [ADDR_W-1:0]       round_q, round_d;
  logic                    kv_q, kv_d;
  logic                    rdy_q, rdy_d;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [SPECK_WORD_W-1:0] wr_data;
`ifdef SPECK_KS_TIMEOUT_EN
  logic [3:0]              wd_q, wd_d;
  logic                    to_q, to_d;
`endif

  always_comb begin
    state_d  = state_q;
    kl_d     = kl_q;
    round_d  = round_q;
    kv_d     = kv_q;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    ks_start = 1'b0;
    done     = 1'b0;
`ifdef SPECK_KS_TIMEOUT_EN
    wd_d     = '0;
    to_d     = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_valid && rdy_q) begin
          kl_d    = key;
          round_d = '0;
          kv_d    = 1'b0;
          wr_en   = 1'b1;
          wr_data = key[127:64];
          state_d = KICK;
`ifdef SPECK_KS_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      // A key_schedule left running across our reset must drain before we start it.
      KICK: begin
        if (ks_state == 4'd0) begin
          ks_start = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (ks_finished) begin
          kl_d    = ks_out_key;
          wr_en   = 1'b1;
          wr_addr = round_q + ADDR_W'(1);
          wr_data = ks_out_key[127:64];
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + ADDR_W'(1);
            state_d = KICK;
          end
        end
`ifdef SPECK_KS_TIMEOUT_EN
        else if (wd_q == 4'(KS_TIMEOUT_CYC - 1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 4'd1;
        end
`endif
      end
      DONE: begin
        kv_d    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kl_q    <= '0;
      round_q <= '0;
      kv_q    <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef SPECK_KS_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      kl_q    <= kl_d;
      round_q <= round_d;
      kv_q    <= kv_d;
      rdy_q   <= rdy_d;
`ifdef SPECK_KS_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  speck_rk_ram #(
    .DEPTH  (ROUNDS),
    .ADDR_W (ADDR_W),
    .DATA_W (SPECK_WORD_W)
  ) u_rk_ram (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rk_rd_addr),
    .rd_data_o (rk_rd_data)
  );

  assign key_ready    = rdy_q;
  assign keys_valid   = kv_q;
  assign ks_key       = kl_q;
  assign ks_round_ctr = SPECK_WORD_W'(round_q);
  assign dbg_state    = state_q;
`ifdef SPECK_KS_TIMEOUT_EN
  assign ks_timeout   = to_q;
`endif
endmodule

// File: tb/tb_speck_round_key_ctrl.sv
// Directed bench for speck_round_key_ctrl with a 7-state key_schedule stand-in and a
// golden round-key model computed straight from the SPECK128/128 key expansion.
module tb_speck_round_key_ctrl;
  localparam int ROUNDS = 32;
  localparam int ADDR_W = 5;

  localparam logic [127:0] K1 = 128'h0706050403020100_0f0e0d0c0b0a0908;
  localparam logic [127:0] K2 = 128'h1f1e1d1c1b1a1918_1716151413121110;
  localparam logic [127:0] K3 = 128'hdeadbeefcafef00d_0123456789abcdef;
  localparam logic [127:0] K4 = 128'h0011223344556677_8899aabbccddeeff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              key_valid;
  logic              key_ready;
  logic [127:0]      key;
  logic              keys_valid;
  logic              done;
  logic [ADDR_W-1:0] rk_rd_addr;
  logic [63:0]       rk_rd_data;
  logic              ks_start;
  logic [127:0]      ks_key;
  logic [63:0]       ks_round_ctr;
  logic              ks_finished;
  logic [127:0]      ks_out_key;
  logic [3:0]        ks_state;
  logic [1:0]        dbg_state;
`ifdef SPECK_KS_TIMEOUT_EN
  logic              ks_timeout;
`endif

  speck_round_key_ctrl #(.ROUNDS(ROUNDS), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key          (key),
    .keys_valid   (keys_valid),
    .done         (done),
    .rk_rd_addr   (rk_rd_addr),
    .rk_rd_data   (rk_rd_data),
    .ks_start     (ks_start),
    .ks_key       (ks_key),
    .ks_round_ctr (ks_round_ctr),
    .ks_finished  (ks_finished),
    .ks_out_key   (ks_out_key),
    .ks_state     (ks_state),
    .dbg_state    (dbg_state)
`ifdef SPECK_KS_TIMEOUT_EN
    ,
    .ks_timeout   (ks_timeout)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [127:0] ks_round(input logic [127:0] kl, input logic [63:0] i);
    logic [63:0] k, l;
    k = kl[127:64];
    l = kl[63:0];
    l = (k + {l[7:0], l[63:8]}) ^ i;
    k = {k[60:0], k[63:61]} ^ l;
    return {k, l};
  endfunction

  logic [63:0] gold [ROUNDS];
  logic [63:0] gold_prev [ROUNDS];

  task automatic make_gold(input logic [127:0] mk);
    logic [127:0] kl;
    kl = mk;
    gold[0] = mk[127:64];
    for (int i = 0; i < ROUNDS - 1; i++) begin
      kl = ks_round(kl, 64'(i));
      gold[i+1] = kl[127:64];
    end
  endtask

  // ---------------- key_schedule stand-in ----------------
  // Samples start at the edge closing the start cycle, walks states 1..7 and
  // reports finished in state 7; it is deliberately unaffected by rst_n.
  int unsigned  ks_s = 0;
  logic [127:0] ks_lat_key = '0;
  logic [63:0]  ks_lat_ctr = '0;
  logic         job_valid = 1'b0;
  logic         spur = 1'b0;
  logic         hold_fin = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) job_valid <= 1'b0;
    if (ks_s == 0) begin
      if (ks_start) begin
        ks_s       <= 1;
        ks_lat_key <= ks_key;
        ks_lat_ctr <= ks_round_ctr;
        job_valid  <= 1'b1;
      end
    end else if (ks_s == 7) begin
      if (!hold_fin) ks_s <= 0;
    end else begin
      ks_s <= ks_s + 1;
    end
  end

  assign ks_state    = 4'(ks_s);
  assign ks_finished = ((ks_s == 7) && !hold_fin) || spur;
  assign ks_out_key  = ks_round(ks_lat_key, ks_lat_ctr);

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          due_q[$];
  int          adr_q[$];

  task automatic issue_read(input int a, input logic [63:0] e);
    rk_rd_addr = ADDR_W'(a);
    exp_q.push_back(e);
    due_q.push_back(cyc + 1);
    adr_q.push_back(a);
  endtask

  task automatic read_all();
    for (int a = 0; a < ROUNDS; a++) begin
      issue_read(a, gold[a]);
      tick();
    end
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] == cyc) begin
      check($sformatf("rk_rd_data[%0d]", adr_q.pop_front()), 128'(rk_rd_data), 128'(exp_q.pop_front()));
      void'(due_q.pop_front());
    end
    if (rst_n) begin
      if (ks_start) check("ks_start_while_ks_busy", 128'(ks_state), 128'(0));
      if (ks_finished && job_valid && !spur) begin
        check("ks_key_hold", ks_key, ks_lat_key);
        check("ks_round_ctr_hold", 128'(ks_round_ctr), 128'(ks_lat_ctr));
      end
    end
  end

  // ---------------- driver ----------------
  // Starts just before the accepting edge; lat counts edges after it until keys_valid.
  task automatic run_sched(input bit hold, input logic [127:0] next_key,
                           output int lat, output int rdy_hi, output int dn, output int fs);
    lat = 0; rdy_hi = 0; dn = 0; fs = -1;
    tick();
    if (hold) key = next_key;
    else key_valid = 1'b0;
    while (!keys_valid && lat < 400) begin
      if (key_ready) rdy_hi++;
      if (done) dn++;
      if (ks_start && fs < 0) fs = lat;
      tick();
      lat++;
    end
  endtask

  int lat, rdy_hi, dn, fs, n;

  initial begin
    key_valid  = 1'b0;
    key        = '0;
    rk_rd_addr = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_key_ready", 128'(key_ready), 128'(0));
    check("rst_keys_valid", 128'(keys_valid), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_ks_start", 128'(ks_start), 128'(0));
    check("rst_ks_key", ks_key, 128'(0));
    check("rst_ks_round_ctr", 128'(ks_round_ctr), 128'(0));
    check("rst_rk_rd_data", 128'(rk_rd_data), 128'(0));
`ifdef SPECK_KS_TIMEOUT_EN
    check("rst_ks_timeout", 128'(ks_timeout), 128'(0));
`endif
    tick();
    tick();
    check("key_ready_in_reset", 128'(key_ready), 128'(0));
    rst_n = 1'b1;
    tick();
    check("key_ready_idle", 128'(key_ready), 128'(1));

    // Reference vector; the two literals pin the model itself.
    make_gold(K1);
    check("model_rk0", 128'(gold[0]), 128'(64'h0706050403020100));
    check("model_rk1", 128'(gold[1]), 128'(64'h37253b31171d0309));
    key = K1;
    key_valid = 1'b1;
    run_sched(1'b0, '0, lat, rdy_hi, dn, fs);
    // Accept cycle + 31 rounds of 8 cycles + DONE = 250 cycles, i.e. 249 edges after accept.
    check("k1_keys_valid_latency", 128'(lat), 128'(249));
    check("k1_done_pulses", 128'(dn), 128'(1));
    check("k1_ready_while_busy", 128'(rdy_hi), 128'(0));
    check("k1_first_kick", 128'(fs), 128'(0));
    check("k1_ready_after", 128'(key_ready), 128'(1));
    read_all();

    // Second key held while busy; third key queued behind it.
    key = K2;
    key_valid = 1'b1;
    make_gold(K2);
    run_sched(1'b1, K3, lat, rdy_hi, dn, fs);
    check("k2_keys_valid_latency", 128'(lat), 128'(249));
    check("k2_ready_while_busy", 128'(rdy_hi), 128'(0));
    check("k2_done_pulses", 128'(dn), 128'(1));
    check("k2_ready_in_idle", 128'(key_ready), 128'(1));
    tick();
    check("k3_accept_drops_keys_valid", 128'(keys_valid), 128'(0));
    check("k3_accept_drops_ready", 128'(key_ready), 128'(0));
    key_valid = 1'b0;
    gold_prev = gold;
    make_gold(K3);

    // Read rk[5] in the cycle it is rewritten: old data first, then new.
    n = 0;
    while (!(ks_finished && ks_round_ctr == 64'd4) && n < 200) begin
      tick();
      n++;
    end
    check("collision_found", 128'(n < 200), 128'(1));
    issue_read(5, gold_prev[5]);
    tick();
    issue_read(5, gold[5]);
    tick();
    tick();

    // Reset just after the round-10 start, while key_schedule keeps running.
    n = 0;
    while (!(ks_start && ks_round_ctr == 64'd10) && n < 200) begin
      tick();
      n++;
    end
    check("round10_found", 128'(n < 200), 128'(1));
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_keys_valid", 128'(keys_valid), 128'(0));
    check("midrst_key_ready", 128'(key_ready), 128'(0));
    tick();
    rst_n = 1'b1;
    key = K4;
    key_valid = 1'b1;
    make_gold(K4);
    tick();
    run_sched(1'b0, '0, lat, rdy_hi, dn, fs);
    check("k4_kick_stall", 128'(fs), 128'(4));
    check("k4_keys_valid_latency", 128'(lat), 128'(253));
    check("k4_done_pulses", 128'(dn), 128'(1));
    read_all();

    // Spurious finish in IDLE must leave state and buffer untouched.
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spur_key_ready", 128'(key_ready), 128'(1));
      check("spur_keys_valid", 128'(keys_valid), 128'(1));
      check("spur_done", 128'(done), 128'(0));
    end
    spur = 1'b0;
    tick();
    read_all();

`ifdef SPECK_KS_TIMEOUT_EN
    hold_fin = 1'b1;
    key = K1;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    n = 0;
    while (!ks_timeout && n < 60) begin
      tick();
      n++;
    end
    check("wd_timeout_cycle", 128'(n), 128'(16));
    check("wd_keys_valid", 128'(keys_valid), 128'(0));
    check("wd_back_idle", 128'(key_ready), 128'(1));
    hold_fin = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
